pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-redirect controller at the IF stage: the consuming end of the branch-target interface.
- Owns the PC register and presents pc_next (PC+1) to the branch adder in the later stage.
- Accepts the resolved branch target plus a taken strobe, redirects fetch, and squashes wrong-path instructions with a counted flush.
- Holds the PC on pipeline stalls and inserts one bubble after reset.

---
 rtl/pc_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Brief    : IF-stage program counter and fetch-redirect controller. Owns the
//             PC, presents PC+1 to the branch adder, redirects on a resolved
//             taken branch and squashes wrong-path work with a counted flush.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter int                   PC_WIDE     = 7,
  parameter logic [PC_WIDE-1:0]   RESET_PC    = '0,
  parameter int                   FLUSH_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,          // asynchronous, active-low
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_WIDE-1:0] branch_pc,
  output logic [PC_WIDE-1:0] pc,
  output logic [PC_WIDE-1:0] pc_next,
  output logic               fetch_valid,
  output logic               flush
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Counter holds the number of flush cycles still to come after this one.
  localparam logic [2:0]         CNT_INIT = 3'(FLUSH_DEPTH - 1);
  localparam logic [PC_WIDE-1:0] PC_ONE   = PC_WIDE'(1);

  state_t             state;
  logic [2:0]         flush_cnt;
  logic [PC_WIDE-1:0] pc_sel;

  // Select the address fetched after this edge; branch_pc is only looked at
  // when a taken branch is accepted, so an X target never leaks into the PC.
  always_comb begin
    pc_sel = pc;
    case (state)
      RUN: begin
        if (branch_taken) begin
          pc_sel = branch_pc;
        end else if (!stall) begin
          pc_sel = pc_next;
        end
      end
      FLUSH: begin
        if (!stall) begin
          pc_sel = pc_next;
        end
      end
      default: pc_sel = pc;
    endcase
  end

  // Fetch FSM with registered PC, PC+1, valid and flush outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_next     <= RESET_PC + PC_ONE;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      flush_cnt   <= 3'd0;
    end else begin
      pc      <= pc_sel;
      pc_next <= pc_sel + PC_ONE;
      case (state)
        BOOT: begin
          // One bubble after reset: PC holds, fetch becomes valid.
          fetch_valid <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          fetch_valid <= 1'b1;
          if (branch_taken) begin
            flush     <= 1'b1;
            flush_cnt <= CNT_INIT;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          // Branches seen here come from squashed instructions: ignored.
          fetch_valid <= 1'b1;
          if (flush_cnt == 3'd0) begin
            flush <= 1'b0;
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          fetch_valid <= 1'b1;
          flush       <= 1'b0;
          flush_cnt   <= 3'd0;
          state       <= RUN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_ctrl
//  Brief    : Self-checking bench for pc_fetch_ctrl: directed scenarios then
//             random stall/branch/reset traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  localparam int PW  = 7;
  localparam int MOD = 1 << PW;
  localparam int FD  = 2;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          branch_taken;
  logic [PW-1:0] branch_pc;
  logic [PW-1:0] pc;
  logic [PW-1:0] pc_next;
  logic          fetch_valid;
  logic          flush;

  int total = 0;
  int bad   = 0;

  // Reference state: current PC, whether fetch is live, flush cycles left.
  int m_pc;
  int m_valid;
  int m_rem;

  pc_fetch_ctrl #(
    .PC_WIDE    (PW),
    .RESET_PC   (7'd0),
    .FLUSH_DEPTH(FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch_taken(branch_taken),
    .branch_pc   (branch_pc),
    .pc          (pc),
    .pc_next     (pc_next),
    .fetch_valid (fetch_valid),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},          int'(pc),          m_pc);
    chk({tag, ".pc_next"},     int'(pc_next),     (m_pc + 1) % MOD);
    chk({tag, ".fetch_valid"}, int'(fetch_valid), m_valid);
    chk({tag, ".flush"},       int'(flush),       (m_rem > 0) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_pc    = 0;
    m_valid = 0;
    m_rem   = 0;
  endtask

  // One clock: drive at negedge, model the edge, check 1 time unit later.
  task automatic step(input string tag, input logic s, input logic b, input int bpc);
    @(negedge clk);
    stall        = s;
    branch_taken = b;
    branch_pc    = b ? PW'(bpc) : 'x;
    @(posedge clk);
    if (rst) begin
      if (m_valid == 0) begin
        m_valid = 1;
      end else if (m_rem > 0) begin
        m_rem--;
        if (!s) m_pc = (m_pc + 1) % MOD;
      end else if (b) begin
        m_pc  = bpc;
        m_rem = FD;
      end else if (!s) begin
        m_pc = (m_pc + 1) % MOD;
      end
    end
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse starting mid-cycle; released just after an edge.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_pc    = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Reset release: bubble, then sequential fetch.
    step("boot",  0, 0, 0);
    step("seq1",  0, 0, 0);
    step("seq2",  0, 0, 0);
    step("seq3",  0, 0, 0);
    step("seq4",  0, 0, 0);
    step("seq5",  0, 0, 0);

    // Taken branch at pc=5 to 40.
    step("br40",  0, 1, 40);
    step("fl41",  0, 0, 0);
    step("fl42",  0, 0, 0);

    // Move to pc=9 via a branch to 7, then stall plus branch to 20.
    step("br7",   0, 1, 7);
    step("fl8",   0, 0, 0);
    step("fl9",   0, 0, 0);
    step("stbr20", 1, 1, 20);
    step("sthold1", 1, 0, 0);
    step("sthold2", 1, 0, 0);
    step("sthold3", 1, 0, 0);

    // Branch while flushing is ignored.
    step("br60",  0, 1, 60);
    step("fl_ign99", 0, 1, 99);
    step("fl_end", 0, 0, 0);

    // Branch to current pc still flushes.
    step("br_self", 0, 1, 62);
    step("bs_fl", 0, 0, 0);
    step("bs_end", 0, 0, 0);

    // Wrap around the top of the address space.
    step("br125", 0, 1, 125);
    step("w126",  0, 0, 0);
    step("w127",  0, 0, 0);
    step("w0",    0, 0, 0);

    // Reset in the middle of a flush.
    step("br40b", 0, 1, 40);
    step("fl41b", 0, 0, 0);
    reset_pulse("rst_midflush");
    step("reboot", 0, 1, 77);
    step("after",  0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse("rnd_rst");
      end else begin
        step("rnd",
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 6) == 0),
             int'($urandom_range(0, MOD - 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
